mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- MEM-stage engine of the 16-bit pipeline. It consumes the registered EX/MEM control and data bundle and performs loads and stores on the data-memory bus with a req/ack handshake.
- It stalls the front of the pipe while an access is outstanding and drives a registered MEM/WB writeback bundle (enable, index, data).
- A timeout counter aborts hung accesses and raises a sticky error.

Parameters:
- TIMEOUT, 15, max ACCESS cycles without MemAck before abort (≥2).
- CNT_W, 4, width of timeout counter; must hold TIMEOUT-1.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- RegWrite_i  in  1  instruction writes register file.
- MemotoReg_i  in  1  writeback data from memory (1) or Result_i (0).
- MemWrite_i  in  1  store.
- MemRead_i  in  1  load.
- Result_i  in  16  ALU result; memory address for loads/stores.
- DataIn_i  in  16  store data.
- RegWriteIndex_i  in  4  destination register.
- MemReq  out  1  bus request, registered.
- MemWe  out  1  1 = write, 0 = read; valid while MemReq.
- MemAddr  out  16  bus address; valid while MemReq.
- MemWData  out  16  store data; valid while MemReq.
- MemRData  in  16  read data; valid in the cycle MemAck=1.
- MemAck  in  1  single-cycle completion strobe.
- Stall  out  1  combinational; freezes upstream stages and the EX/MEM register.
- RegWrite_o  out  1  writeback enable, registered.
- RegWriteIndex_o  out  4  writeback index, registered.
- WbData_o  out  16  writeback data, registered.
- BusErr  out  1  sticky timeout flag.

Behaviour:
- Reset (Rst=0, asynchronous):
  - All outputs and internal registers go to 0; state = IDLE; timeout counter = 0.
  - MemReq drops immediately, even mid-access. The in-flight access is discarded and no writeback occurs.
- States: IDLE, ACCESS.
- IDLE, no memory op (MemRead_i=0, MemWrite_i=0):
  - Stall=0.
  - Next edge: RegWrite_o<=RegWrite_i, RegWriteIndex_o<=RegWriteIndex_i, WbData_o<=Result_i.
  - One-cycle pass-through.
- IDLE, memory op:
  - Stall=1 in the same cycle.
  - Next edge: latch all inputs; MemReq<=1, MemWe<=MemWrite_i, MemAddr<=Result_i, MemWData<=DataIn_i.
  - Load RegWrite_o<=0 (bubble); counter<=0; state<=ACCESS.
- MemRead_i and MemWrite_i both 1: treated as a store; the read is ignored.
- ACCESS:
  - MemReq, MemWe, MemAddr and MemWData are held stable. RegWrite_o=0 every cycle.
  - Stall = !MemAck, so upstream advances on the same edge the access completes.
- ACCESS, MemAck=1 — on the next edge:
  - MemReq<=0; state<=IDLE.
  - RegWrite_o<=latched RegWrite; RegWriteIndex_o<=latched index.
  - WbData_o<=MemRData if latched MemotoReg=1, else latched Result.
  - Minimum load/store occupancy is 2 cycles (ack in the first ACCESS cycle).
- ACCESS, MemAck=0 and counter=TIMEOUT-1 — abort:
  - Stall=0 in this cycle.
  - Next edge: MemReq<=0, BusErr<=1, RegWrite_o<=0, state<=IDLE.
- ACCESS, MemAck=0 and counter<TIMEOUT-1: counter increments.
- Ack and timeout in the same cycle: ack wins; the access completes normally.
- MemAck while in IDLE: ignored.
- BusErr is cleared only by reset.
- Back-to-back memory ops: the instruction presented after completion is evaluated in IDLE on the following cycle. There is no overlap of accesses.
- Between accesses, MemWe, MemAddr and MemWData retain their last values.

Test Plan:
- Reset mid-access:
  - Stimulus: load issued, MemReq=1, then Rst pulled low between clock edges.
  - Response: MemReq=0 and Stall=0 immediately, all outputs 0; after release, no writeback occurs.
- ALU pass-through:
  - Stimulus: RegWrite_i=1, index=5, Result_i=0x1234, no mem op.
  - Response: next cycle RegWrite_o=1, RegWriteIndex_o=5, WbData_o=0x1234; Stall never asserted.
- Load with 3-cycle ack delay:
  - Stimulus: MemRead_i=1, MemotoReg_i=1, Result_i=0x0040, index=3; MemAck=1 with MemRData=0xBEEF in the 3rd ACCESS cycle.
  - Response: MemReq=1, MemWe=0, MemAddr=0x0040 for 3 cycles; Stall=1 until the ack cycle; then RegWrite_o=1, index 3, WbData_o=0xBEEF.
- Store:
  - Stimulus: MemWrite_i=1, Result_i=0x0010, DataIn_i=0xA5A5, RegWrite_i=0; immediate ack.
  - Response: MemWe=1, MemWData=0xA5A5 for one cycle; RegWrite_o stays 0.
- Timeout, TIMEOUT=4:
  - Stimulus: load issued, MemAck held 0.
  - Response: MemReq high exactly 4 cycles; BusErr=1 afterwards; RegWrite_o=0.
  - Repeat with the ack arriving in the 4th cycle: the access completes and BusErr stays 0.
- Back-to-back loads:
  - Stimulus: two consecutive loads, each acked in the first ACCESS cycle.
  - Response: each occupies 2 cycles; writebacks appear in order with the correct data.

Source files
------------

// File: rtl/mem_access.sv
// MEM stage: one-cycle pass-through for ALU ops; loads/stores go over a req/ack bus (min 2 cycles, abort after TIMEOUT).
// Backpressure: Stall holds upstream while an access is outstanding and drops in the ack or abort cycle.
module mem_access #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        RegWrite_i,
    input  logic        MemotoReg_i,
    input  logic        MemWrite_i,
    input  logic        MemRead_i,
    input  logic [15:0] Result_i,
    input  logic [15:0] DataIn_i,
    input  logic [3:0]  RegWriteIndex_i,
    output logic        MemReq,
    output logic        MemWe,
    output logic [15:0] MemAddr,
    output logic [15:0] MemWData,
    input  logic [15:0] MemRData,
    input  logic        MemAck,
    output logic        Stall,
    output logic        RegWrite_o,
    output logic [3:0]  RegWriteIndex_o,
    output logic [15:0] WbData_o,
    output logic        BusErr
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rw_q;
    logic             m2r_q;
    logic [3:0]       idx_q;
    logic [15:0]      res_q;
    logic             mem_op;
    logic             at_limit;

    assign mem_op   = MemRead_i | MemWrite_i;
    assign at_limit = (cnt_q == CNT_MAX);

    // Stall is forced low during reset so upstream is never frozen by a discarded access.
    always_comb begin
        Stall = 1'b0;
        if (Rst) begin
            if (state_q == IDLE) Stall = mem_op;
            else                 Stall = !MemAck && !at_limit;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            rw_q            <= 1'b0;
            m2r_q           <= 1'b0;
            idx_q           <= '0;
            res_q           <= '0;
            MemReq          <= 1'b0;
            MemWe           <= 1'b0;
            MemAddr         <= '0;
            MemWData        <= '0;
            RegWrite_o      <= 1'b0;
            RegWriteIndex_o <= '0;
            WbData_o        <= '0;
            BusErr          <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_op) begin
                        MemReq     <= 1'b1;
                        MemWe      <= MemWrite_i;
                        MemAddr    <= Result_i;
                        MemWData   <= DataIn_i;
                        rw_q       <= RegWrite_i;
                        m2r_q      <= MemotoReg_i;
                        idx_q      <= RegWriteIndex_i;
                        res_q      <= Result_i;
                        RegWrite_o <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= ACCESS;
                    end else begin
                        RegWrite_o      <= RegWrite_i;
                        RegWriteIndex_o <= RegWriteIndex_i;
                        WbData_o        <= Result_i;
                    end
                end
                ACCESS: begin
                    // Ack takes priority over an expiring counter.
                    if (MemAck) begin
                        MemReq          <= 1'b0;
                        state_q         <= IDLE;
                        RegWrite_o      <= rw_q;
                        RegWriteIndex_o <= idx_q;
                        WbData_o        <= m2r_q ? MemRData : res_q;
                    end else if (at_limit) begin
                        MemReq     <= 1'b0;
                        BusErr     <= 1'b1;
                        RegWrite_o <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        cnt_q      <= cnt_q + CNT_W'(1);
                        RegWrite_o <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

    localparam int TO = 4;

    logic        Clk;
    logic        Rst;
    logic        RegWrite_i;
    logic        MemotoReg_i;
    logic        MemWrite_i;
    logic        MemRead_i;
    logic [15:0] Result_i;
    logic [15:0] DataIn_i;
    logic [3:0]  RegWriteIndex_i;
    logic        MemReq;
    logic        MemWe;
    logic [15:0] MemAddr;
    logic [15:0] MemWData;
    logic [15:0] MemRData;
    logic        MemAck;
    logic        Stall;
    logic        RegWrite_o;
    logic [3:0]  RegWriteIndex_o;
    logic [15:0] WbData_o;
    logic        BusErr;

    mem_access #(.TIMEOUT(TO), .CNT_W(3)) dut (
        .Clk(Clk), .Rst(Rst),
        .RegWrite_i(RegWrite_i), .MemotoReg_i(MemotoReg_i),
        .MemWrite_i(MemWrite_i), .MemRead_i(MemRead_i),
        .Result_i(Result_i), .DataIn_i(DataIn_i), .RegWriteIndex_i(RegWriteIndex_i),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemRData(MemRData), .MemAck(MemAck), .Stall(Stall),
        .RegWrite_o(RegWrite_o), .RegWriteIndex_o(RegWriteIndex_o),
        .WbData_o(WbData_o), .BusErr(BusErr)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [19:0] wb_q[$];   // {index, data} expected writebacks in order
    logic [32:0] req_q[$];  // {we, addr, wdata} expected bus requests in order
    logic        model_err = 1'b0;
    logic        req_prev  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected bus requests and writebacks as the DUT presents them.
    always @(negedge Clk) begin
        if (!Rst) begin
            req_prev <= 1'b0;
        end else begin
            req_prev <= MemReq;
            if (MemReq && !req_prev) begin
                if (req_q.size() == 0) check("unexpected_req", {15'd0, MemWe, MemAddr}, 32'hFFFF_FFFF);
                else check("req_fields", {MemWe, MemAddr, MemWData}, {req_q.pop_front()});
            end
            if (RegWrite_o) begin
                if (wb_q.size() == 0) check("unexpected_wb", {12'd0, RegWriteIndex_o, WbData_o}, 32'hFFFF_FFFF);
                else check("wb_fields", {12'd0, RegWriteIndex_o, WbData_o}, {12'd0, wb_q.pop_front()});
            end
            check("buserr", {31'd0, BusErr}, {31'd0, model_err});
        end
    end

    // ack_at: ACCESS cycle (1..TO) in which MemAck pulses; 0 means never (timeout).
    task automatic issue(input logic rw, input logic m2r, input logic mw, input logic mr,
                         input logic [15:0] res, input logic [15:0] din, input logic [3:0] idx,
                         input int ack_at, input logic idle_ack);
        logic        mem;
        logic        ack;
        logic [15:0] rd;
        mem = mw | mr;
        RegWrite_i = rw; MemotoReg_i = m2r; MemWrite_i = mw; MemRead_i = mr;
        Result_i = res; DataIn_i = din; RegWriteIndex_i = idx;
        MemAck = idle_ack; MemRData = 16'($urandom);
        if (mem) req_q.push_back({mw, res, din});
        @(negedge Clk);
        check("idle_stall", {31'd0, Stall}, {31'd0, mem});
        check("idle_req", {31'd0, MemReq}, 32'd0);
        if (!mem && rw) wb_q.push_back({idx, res});
        @(posedge Clk); #1;
        MemAck = 1'b0;
        if (mem) begin
            // Upstream values are irrelevant once latched.
            RegWrite_i = 1'($urandom); MemotoReg_i = 1'($urandom);
            MemWrite_i = 1'($urandom); MemRead_i = 1'($urandom);
            Result_i = 16'($urandom); DataIn_i = 16'($urandom); RegWriteIndex_i = 4'($urandom);
            for (int k = 1; k <= TO; k++) begin
                ack = (k == ack_at);
                rd  = 16'($urandom);
                MemAck = ack; MemRData = rd;
                @(negedge Clk);
                check("acc_stall", {31'd0, Stall}, {31'd0, (!ack && k != TO)});
                check("acc_req", {31'd0, MemReq}, 32'd1);
                check("acc_bus", {MemWe, MemAddr, MemWData}, {mw, res, din});
                check("acc_rw_low", {31'd0, RegWrite_o}, 32'd0);
                if (ack && rw) wb_q.push_back({idx, m2r ? rd : res});
                @(posedge Clk); #1;
                MemAck = 1'b0;
                if (ack) break;
                if (k == TO) model_err = 1'b1;
            end
        end
    endtask

    task automatic nop();
        issue(1'b0, 1'b0, 1'b0, 1'b0, 16'($urandom), 16'($urandom), 4'($urandom), 0, 1'b0);
    endtask

    task automatic rand_op(input int min_ack);
        int op;
        op = int'($urandom_range(0, 3));
        issue(1'($urandom), 1'($urandom), op >= 2, op == 1 || op == 3,
              16'($urandom), 16'($urandom), 4'($urandom),
              int'($urandom_range(min_ack, TO)), 1'($urandom));
    endtask

    initial begin
        Rst = 1'b0;
        RegWrite_i = 0; MemotoReg_i = 0; MemWrite_i = 0; MemRead_i = 0;
        Result_i = 0; DataIn_i = 0; RegWriteIndex_i = 0; MemRData = 0; MemAck = 0;
        #12;
        check("rst_outputs", {MemReq, MemWe, MemAddr, MemWData, Stall, RegWrite_o},
              32'd0);
        check("rst_wb", {RegWriteIndex_o, WbData_o, BusErr}, 32'd0);
        @(posedge Clk); #1;
        Rst = 1'b1;

        // Reset mid-access: a pending load is discarded without writeback.
        RegWrite_i = 1; MemotoReg_i = 1; MemRead_i = 1; Result_i = 16'h0077;
        RegWriteIndex_i = 4'd9;
        req_q.push_back({1'b0, 16'h0077, 16'h0000});
        @(posedge Clk); #1;
        @(posedge Clk); #2;
        check("pre_rst_req", {31'd0, MemReq}, 32'd1);
        Rst = 1'b0;
        #1;
        check("mid_rst_req_stall", {30'd0, MemReq, Stall}, 32'd0);
        check("mid_rst_bus", {MemWe, MemAddr, MemWData}, 32'd0);
        check("mid_rst_wb", {11'd0, RegWrite_o, RegWriteIndex_o, WbData_o}, 32'd0);
        @(posedge Clk); #1;
        Rst = 1'b1;
        nop(); nop();

        // ALU pass-through, with a stray ack in IDLE.
        issue(1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0, 4'd5, 0, 1'b1);
        nop();
        // Load, ack in 3rd ACCESS cycle.
        issue(1'b1, 1'b1, 1'b0, 1'b1, 16'h0040, 16'h0, 4'd3, 3, 1'b0);
        // Store with immediate ack, no writeback.
        issue(1'b0, 1'b0, 1'b1, 1'b0, 16'h0010, 16'hA5A5, 4'd1, 1, 1'b0);
        // Read+write together acts as a store.
        issue(1'b0, 1'b0, 1'b1, 1'b1, 16'h0020, 16'h5A5A, 4'd2, 2, 1'b0);
        // Ack in the last allowed cycle completes normally.
        issue(1'b1, 1'b1, 1'b0, 1'b1, 16'h0050, 16'h0, 4'd7, TO, 1'b0);
        // Back-to-back loads.
        issue(1'b1, 1'b1, 1'b0, 1'b1, 16'h0100, 16'h0, 4'd4, 1, 1'b0);
        issue(1'b1, 1'b1, 1'b0, 1'b1, 16'h0102, 16'h0, 4'd6, 1, 1'b0);
        nop();

        for (int i = 0; i < 60; i++) rand_op(1);

        // Timeout: load never acked.
        issue(1'b1, 1'b1, 1'b0, 1'b1, 16'h0200, 16'h0, 4'd8, 0, 1'b0);
        nop();
        for (int i = 0; i < 40; i++) rand_op(0);
        nop(); nop();

        check("wb_queue_drained", wb_q.size(), 32'd0);
        check("req_queue_drained", req_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
